sdram_rw_scheduler: RTL and testbench

//  Decides which operation the FIFO-to-SDRAM bridge runs next: a read or a write. It sits between
//  the AXI-side address/data FIFOs and the bridge, and replaces the fixed RW FIFO ordering.

---
 rtl/sdram_rw_scheduler.sv | 115 +++++++++++
 tb/tb_sdram_rw_scheduler.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/sdram_rw_scheduler.sv
// Read/write arbiter for the FIFO-to-SDRAM bridge: read priority, write-drain watermarks,
// anti-starvation forcing, direction-change turnaround gap and a completion watchdog.
module sdram_rw_scheduler #(
    parameter int LVL_W      = 5,
    parameter int WR_HI_WM   = 12,
    parameter int WR_LO_WM   = 4,
    parameter int MAX_STARVE = 4,
    parameter int TURN_CYC   = 2,
    parameter int TO_W       = 8
) (
    input  logic             SD_clk,
    input  logic             ARESETn,
    input  logic             WADDR_FIFO_EMPTY,
    input  logic             WDATA_FIFO_EMPTY,
    input  logic             RADDR_FIFO_EMPTY,
    input  logic             RDATA_FIFO_FULL,
    input  logic [LVL_W-1:0] WR_LEVEL,
    input  logic             busy,
    output logic             op_valid,
    output logic             op_write,
    input  logic             op_ack,
    input  logic             op_done,
    output logic             drain_mode,
    output logic             timeout_err
);
    localparam int SK_W = $clog2(MAX_STARVE + 1);
    localparam int GP_W = (TURN_CYC > 1) ? $clog2(TURN_CYC) : 1;

    typedef enum logic [2:0] {IDLE, ARB, GAP, ISSUE, WAIT_DONE} state_t;

    state_t          state, nxt;
    logic            dir, last_dir, pick_wr, grant, timeout;
    logic [SK_W-1:0] rd_skip, wr_skip;
    logic [GP_W-1:0] gap_cnt;
    logic [TO_W-1:0] wdog;
    logic            wr_elig, rd_elig, rd_force, wr_force;

    assign wr_elig  = !WADDR_FIFO_EMPTY && !WDATA_FIFO_EMPTY;
    assign rd_elig  = !RADDR_FIFO_EMPTY && !RDATA_FIFO_FULL;
    assign rd_force = rd_skip >= SK_W'(MAX_STARVE);
    assign wr_force = wr_skip >= SK_W'(MAX_STARVE);
    // Watchdog fires on the cycle its count would become all-ones.
    assign timeout  = (state == WAIT_DONE) && !op_done && (wdog == {{(TO_W-1){1'b1}}, 1'b0});

    assign op_valid = (state == ISSUE);
    assign op_write = dir;

    always_comb begin
        nxt     = state;
        grant   = 1'b0;
        pick_wr = dir;
        unique case (state)
            IDLE: if (!busy) nxt = ARB;
            ARB: begin
                nxt = IDLE;
                if (!busy) begin
                    if (rd_elig && rd_force) begin
                        grant = 1'b1; pick_wr = 1'b0;
                    end else if (wr_elig && (drain_mode || wr_force)) begin
                        grant = 1'b1; pick_wr = 1'b1;
                    end else if (rd_elig) begin
                        grant = 1'b1; pick_wr = 1'b0;
                    end else if (wr_elig) begin
                        grant = 1'b1; pick_wr = 1'b1;
                    end
                    if (grant)
                        nxt = ((pick_wr != last_dir) && (TURN_CYC > 0)) ? GAP : ISSUE;
                end
            end
            GAP:       if (gap_cnt == GP_W'(TURN_CYC - 1)) nxt = ISSUE;
            ISSUE:     if (op_ack) nxt = op_done ? IDLE : WAIT_DONE;
            WAIT_DONE: if (op_done || timeout) nxt = IDLE;
            default:   nxt = IDLE;
        endcase
    end

    always_ff @(posedge SD_clk) begin
        if (!ARESETn) begin
            state       <= IDLE;
            dir         <= 1'b0;
            last_dir    <= 1'b0;
            rd_skip     <= '0;
            wr_skip     <= '0;
            gap_cnt     <= '0;
            wdog        <= '0;
            drain_mode  <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state <= nxt;
            if (WR_LEVEL >= LVL_W'(WR_HI_WM))
                drain_mode <= 1'b1;
            else if (WR_LEVEL <= LVL_W'(WR_LO_WM))
                drain_mode <= 1'b0;
            // Loser's counter only advances when it actually had work; saturates at the force level.
            if (grant) begin
                dir <= pick_wr;
                if (pick_wr) begin
                    wr_skip <= '0;
                    if (rd_elig && !rd_force) rd_skip <= rd_skip + 1'b1;
                end else begin
                    rd_skip <= '0;
                    if (wr_elig && !wr_force) wr_skip <= wr_skip + 1'b1;
                end
            end
            gap_cnt <= (state == GAP) ? gap_cnt + 1'b1 : '0;
            if (state == ISSUE && op_ack) begin
                last_dir <= dir;
                wdog     <= '0;
            end else if (state == WAIT_DONE) begin
                wdog <= wdog + 1'b1;
            end
            if (timeout) timeout_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_sdram_rw_scheduler.sv
// Randomized bench for sdram_rw_scheduler: acts as the bridge and predicts each grant
// from the arbitration rules with a transaction-level model.
module tb_sdram_rw_scheduler;
    localparam int MS = 4, TC = 2, HI = 12, LO = 4;

    logic       SD_clk = 1'b0, ARESETn = 1'b0;
    logic       waddr_e = 1'b1, wdata_e = 1'b1, raddr_e = 1'b1, rfull = 1'b0;
    logic       busy = 1'b0, op_ack = 1'b0, op_done = 1'b0;
    logic [4:0] wr_level = '0;
    logic       op_valid, op_write, drain_mode, timeout_err;

    int total = 0, bad = 0, cyc = 0;
    int m_rskip = 0, m_wskip = 0, m_last = 0, done_cyc = 0;
    bit m_drain = 1'b0, lat_ok = 1'b0;

    sdram_rw_scheduler dut (
        .SD_clk(SD_clk), .ARESETn(ARESETn),
        .WADDR_FIFO_EMPTY(waddr_e), .WDATA_FIFO_EMPTY(wdata_e),
        .RADDR_FIFO_EMPTY(raddr_e), .RDATA_FIFO_FULL(rfull),
        .WR_LEVEL(wr_level), .busy(busy),
        .op_valid(op_valid), .op_write(op_write),
        .op_ack(op_ack), .op_done(op_done),
        .drain_mode(drain_mode), .timeout_err(timeout_err)
    );

    always #5 SD_clk = ~SD_clk;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge SD_clk);
        #1;
        cyc++;
    endtask

    task automatic set_lvl(input int lvl);
        wr_level = 5'(lvl);
        if (lvl >= HI) m_drain = 1'b1;
        else if (lvl <= LO) m_drain = 1'b0;
    endtask

    task automatic set_in(input bit we, input bit re, input bit full);
        waddr_e = !we; wdata_e = !we; raddr_e = !re; rfull = full;
    endtask

    task automatic rand_in();
        int m;
        m = $urandom_range(0, 9);
        waddr_e = (m == 0); wdata_e = (m == 1); raddr_e = (m == 2); rfull = (m == 3);
        if ($urandom_range(0, 15) == 0) begin waddr_e = 1'b1; raddr_e = 1'b1; end
        set_lvl($urandom_range(0, 20));
    endtask

    // Next grant from the priority rules: 1 = write, 0 = read, -1 = nothing eligible.
    function automatic int predict(input bit we, input bit re);
        if (re && m_rskip >= MS) return 0;
        if (we && (m_drain || m_wskip >= MS)) return 1;
        if (re) return 0;
        if (we) return 1;
        return -1;
    endfunction

    // kind: 0 normal completion, 1 withhold op_done (watchdog), 2 reset while waiting for done.
    task automatic do_op(input bit rerand, input int lvl, input int kind);
        int d, n;
        bit we, re, same, seen;
        we = !waddr_e && !wdata_e;
        re = !raddr_e && !rfull;
        d  = predict(we, re);
        if (d < 0) begin
            seen = 1'b0;
            repeat (12) begin tick(); seen |= op_valid; end
            chk("no_grant", seen, 0);
            lat_ok = 1'b0;
            if (rerand) set_in(1'b1, 1'b1, 1'b0);
            return;
        end
        n = 0;
        while (!op_valid && n < 80) begin tick(); n++; end
        chk("grant_seen", op_valid, 1);
        if (!op_valid) begin lat_ok = 1'b0; return; end
        if (lat_ok) chk("latency", cyc - done_cyc, 3 + ((d != m_last) ? TC : 0));
        chk("dir", op_write, d);
        chk("drain", drain_mode, m_drain);
        if (d == 1) begin
            m_wskip = 0;
            if (re) m_rskip = (m_rskip + 1 > MS) ? MS : m_rskip + 1;
        end else begin
            m_rskip = 0;
            if (we) m_wskip = (m_wskip + 1 > MS) ? MS : m_wskip + 1;
        end
        m_last = d;
        repeat ($urandom_range(0, 2)) begin
            tick();
            chk("hold", {op_valid, op_write}, 2 + d);
        end
        same = (kind == 0) && !rerand && (lvl < 0) && ($urandom_range(0, 3) == 0);
        op_ack = 1'b1; op_done = same;
        tick();
        op_ack = 1'b0; op_done = 1'b0;
        chk("ack_drop", op_valid, 0);
        lat_ok = 1'b0;
        if (same) begin done_cyc = cyc - 1; lat_ok = 1'b1; return; end
        if (kind == 1) begin
            repeat (200) tick();
            chk("tmo_early", timeout_err, 0);
            repeat (100) tick();
            chk("tmo_set", timeout_err, 1);
            return;
        end
        if (kind == 2) begin
            ARESETn = 1'b0;
            tick();
            chk("rst_valid", op_valid, 0);
            chk("rst_write", op_write, 0);
            chk("rst_drain", drain_mode, 0);
            chk("rst_tmo", timeout_err, 0);
            ARESETn = 1'b1;
            m_rskip = 0; m_wskip = 0; m_last = 0; m_drain = 1'b0;
            set_lvl(int'(wr_level));
            return;
        end
        if (rerand) rand_in();
        if (lvl >= 0) set_lvl(lvl);
        repeat ($urandom_range(0, 3)) tick();
        op_done  = 1'b1;
        done_cyc = cyc;
        tick();
        op_done = 1'b0;
        lat_ok  = 1'b1;
    endtask

    initial begin
        bit seen;
        repeat (3) tick();
        chk("reset_valid", op_valid, 0);
        chk("reset_write", op_write, 0);
        chk("reset_drain", drain_mode, 0);
        chk("reset_tmo", timeout_err, 0);
        // Reads only.
        set_in(1'b0, 1'b1, 1'b0);
        ARESETn = 1'b1;
        repeat (6) do_op(1'b0, -1, 0);
        // Both sides eligible at low level: starvation forcing and turnaround gaps.
        set_in(1'b1, 1'b1, 1'b0);
        repeat (15) do_op(1'b0, -1, 0);
        // Level ramp into drain mode, hold, then back out through the hysteresis band.
        do_op(1'b0, 6, 0);
        do_op(1'b0, 10, 0);
        do_op(1'b0, 12, 0);
        repeat (10) do_op(1'b0, -1, 0);
        do_op(1'b0, 8, 0);
        repeat (3) do_op(1'b0, 4, 0);
        chk("drain_clear", drain_mode, 0);
        // Read data FIFO full with only reads pending: nothing granted.
        set_in(1'b0, 1'b1, 1'b1);
        do_op(1'b0, -1, 0);
        set_in(1'b1, 1'b1, 1'b0);
        do_op(1'b0, -1, 0);
        // Watchdog, then the next op is still issued.
        do_op(1'b0, -1, 1);
        do_op(1'b0, -1, 0);
        // busy while arbitrating: no grant.
        tick();
        busy = 1'b1;
        seen = 1'b0;
        repeat (15) begin tick(); seen |= op_valid; end
        chk("busy_no_grant", seen, 0);
        busy   = 1'b0;
        lat_ok = 1'b0;
        do_op(1'b0, 20, 0);
        chk("drain_pre_rst", drain_mode, 1);
        do_op(1'b0, -1, 2);
        do_op(1'b0, -1, 0);
        // Randomized traffic.
        repeat (250) do_op(1'b1, -1, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL global_timeout: got=%0d exp=%0d", cyc, 0);
        $fatal(1);
    end
endmodule
